// File: rtl/tile_transposer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_transposer_pkg : shared types for the streaming transposer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tile_transposer_pkg;

  localparam int unsigned ELEM_W = 8;

  typedef enum logic [1:0] {
    MODE_TRANSPOSE = 2'b00,
    MODE_BYPASS    = 2'b01,
    MODE_ROT90     = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [ELEM_W-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/tile_transposer_v2_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_bank : TILE x TILE element store, row write, mode beat read |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tile_bank
  import tile_transposer_pkg::*;
#(
  parameter int EW   = 8,
  parameter int TILE = 8
) (
  input  logic                      clk,
  input  logic                      wr_en_i,
  input  logic [$clog2(TILE)-1:0]   wr_row_i,
  input  logic [TILE*EW-1:0]        wr_data_i,
  input  mode_e                     rd_mode_i,
  input  logic [$clog2(TILE)-1:0]   rd_beat_i,
  output logic [TILE*EW-1:0]        rd_data_o
);

  logic [EW-1:0] mem_q [TILE][TILE];
  logic [EW-1:0] mem_d [TILE][TILE];
  logic [EW-1:0] row_w [TILE];

  for (genvar c = 0; c < TILE; c++) begin : g_unpack
    assign row_w[c] = wr_data_i[c*EW +: EW];
  end

  // Reads see the row being written this cycle so a freshly filled tile
  // can be presented on the very next cycle.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_row_i] = row_w;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < TILE; i++) begin : g_read
    assign rd_data_o[i*EW +: EW] =
      (rd_mode_i == MODE_TRANSPOSE) ? mem_d[i][rd_beat_i]          :
      (rd_mode_i == MODE_ROT90)     ? mem_d[TILE-1-i][rd_beat_i]   :
                                      mem_d[rd_beat_i][i];
  end

endmodule
`default_nettype wire

// File: rtl/tile_transposer_v2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_transposer_v2 : ping-pong streaming square-tile transposer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tile_transposer_v2
  import tile_transposer_pkg::*;
#(
  parameter int AW   = 16,
  parameter int EW   = 8,
  parameter int TILE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_pulse,
  input  logic [1:0]          mode,
  input  logic [AW-1:0]       tile_num,
  input  logic [TILE*EW-1:0]  in_data,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [TILE*EW-1:0]  out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                busy,
  output logic [AW-1:0]       tile_cnt,
  output logic                finish
);

  localparam int RW = $clog2(TILE);
  localparam int CW = AW + RW;
  localparam logic [RW-1:0] LAST_IDX = RW'(TILE - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [AW-1:0]      tile_num_q, tile_num_d;
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [RW-1:0]      wr_row_q, wr_row_d;
  logic [RW-1:0]      rd_beat_q, rd_beat_d;
  logic [CW-1:0]      rows_in_q, rows_in_d;
  logic [AW-1:0]      tile_cnt_q, tile_cnt_d;
  logic [TILE*EW-1:0] out_data_q, out_data_d;

  logic               in_acc;
  logic               out_acc;
  logic [TILE*EW-1:0] bank_rd [2];

  assign in_rdy  = (state_q == RUN) && !init_pulse && !full_q[wr_bank_q]
                   && (rows_in_q < {tile_num_q, {RW{1'b0}}});
  assign out_vld = (state_q == RUN) && !init_pulse && full_q[rd_bank_q];
  assign in_acc  = in_vld && in_rdy;
  assign out_acc = out_vld && out_rdy;

  assign busy     = (state_q == RUN);
  assign finish   = (state_q == DONE);
  assign tile_cnt = tile_cnt_q;
  assign out_data = out_data_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .EW   (EW),
      .TILE (TILE)
    ) u_bank (
      .clk       (clk),
      .wr_en_i   (in_acc && (wr_bank_q == 1'(b))),
      .wr_row_i  (wr_row_q),
      .wr_data_i (in_data),
      .rd_mode_i (mode_q),
      .rd_beat_i (rd_beat_d),
      .rd_data_o (bank_rd[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tile_num_d = tile_num_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_beat_d  = rd_beat_q;
    rows_in_d  = rows_in_q;
    tile_cnt_d = tile_cnt_q;
    if (init_pulse) begin
      mode_d     = mode_e'(mode);
      tile_num_d = tile_num;
      full_d     = '0;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_row_d   = '0;
      rd_beat_d  = '0;
      rows_in_d  = '0;
      tile_cnt_d = '0;
      state_d    = (tile_num != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          if (in_acc) begin
            rows_in_d = rows_in_q + CW'(1);
            wr_row_d  = wr_row_q + RW'(1);
            if (wr_row_q == LAST_IDX) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = !wr_bank_q;
            end
          end
          if (out_acc) begin
            rd_beat_d = rd_beat_q + RW'(1);
            if (rd_beat_q == LAST_IDX) begin
              full_d[rd_bank_q] = 1'b0;
              rd_bank_d         = !rd_bank_q;
              tile_cnt_d        = tile_cnt_q + AW'(1);
              if (tile_cnt_d == tile_num_q) begin
                state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end
  end

  // Preload the beat that will be on the bus next cycle; while stalled the
  // same bank/beat is re-read, so the register holds its value.
  always_comb begin
    out_data_d = out_data_q;
    if ((state_d == RUN) && full_d[rd_bank_d]) begin
      out_data_d = bank_rd[rd_bank_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_TRANSPOSE;
      tile_num_q <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_beat_q  <= '0;
      rows_in_q  <= '0;
      tile_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tile_num_q <= tile_num_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_beat_q  <= rd_beat_d;
      rows_in_q  <= rows_in_d;
      tile_cnt_q <= tile_cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
`default_nettype wire
